// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo slice.
// Optional error flags are enabled with SYNC_FIFO_ERR_FLAGS_EN (see sync_fifo.sv).
package sync_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Pointer width for a power-of-two depth; the count needs one extra bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bus for sync_fifo; the FIFO takes the slave modport.
// overflow_o/underflow_o exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_if #(
  parameter int WIDTH = sync_fifo_pkg::DEFAULT_WIDTH
);

  // Handshake: write_en is a request that is taken on a rising edge when
  // !full_o || read_en; read_en is taken when !empty_o, and the popped entry
  // appears on data_o the following cycle. Requests that are not taken are
  // simply ignored, so the master re-asserts until the flags allow it.
  logic             write_en;
  logic             read_en;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] data_o;
  logic             full_o;
  logic             empty_o;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic             overflow_o;
  logic             underflow_o;
`endif

  modport master (
    output write_en, read_en, data_i,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    input  overflow_o, underflow_o,
`endif
    input  data_o, full_o, empty_o
  );

  modport slave (
    input  write_en, read_en, data_i,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output overflow_o, underflow_o,
`endif
    output data_o, full_o, empty_o
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage with one write port and a registered read port.
// Array contents are not reset; only the read register is.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A same-edge write to rd_addr (full FIFO, read+write) returns the old entry.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count and status flags around sync_fifo_mem.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow_o/underflow_o.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk_i,
  input  logic        reset_i,
  sync_fifo_if.slave  bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] write_ptr;
  logic [PTR_W-1:0] read_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_ok;
  logic             rd_ok;

  // A full FIFO still takes a write when the same edge pops an entry.
  assign wr_ok = bus.write_en && (!bus.full_o || bus.read_en);
  assign rd_ok = bus.read_en && !bus.empty_o;

  assign bus.full_o  = (count == FULL_COUNT);
  assign bus.empty_o = (count == '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count     <= '0;
    end else begin
      if (wr_ok) begin
        write_ptr <= write_ptr + PTR_W'(1);
      end
      if (rd_ok) begin
        read_ptr <= read_ptr + PTR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .wr_en   (wr_ok),
    .wr_addr (write_ptr),
    .wr_data (bus.data_i),
    .rd_en   (rd_ok),
    .rd_addr (read_ptr),
    .rd_data (bus.data_o)
  );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.write_en && bus.full_o && !bus.read_en) begin
        overflow_q <= 1'b1;
      end
      if (bus.read_en && bus.empty_o) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflow_o  = overflow_q;
  assign bus.underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed test-plan sequences plus random traffic
// compared against a queue-based reference model.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int W = DEFAULT_WIDTH;
  localparam int D = DEFAULT_DEPTH;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_if #(.WIDTH(W)) bus ();

  sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_data;
  logic         exp_ovf;
  logic         exp_unf;
  int           tests_run;
  int           tests_failed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data_o"},  32'(bus.data_o),  32'(exp_data));
    check({tag, ".empty_o"}, 32'(bus.empty_o), 32'(exp_q.size() == 0));
    check({tag, ".full_o"},  32'(bus.full_o),  32'(exp_q.size() == D));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check({tag, ".overflow_o"},  32'(bus.overflow_o),  32'(exp_ovf));
    check({tag, ".underflow_o"}, 32'(bus.underflow_o), 32'(exp_unf));
`endif
  endtask

  function automatic void model_reset();
    exp_q.delete();
    exp_data = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endfunction

  // ---------------- driver ----------------
  // Drive on the falling edge, let the rising edge act, check 1 time unit later.
  task automatic step(input string tag, input logic we, input logic re, input logic [W-1:0] din);
    int  occ;
    logic do_wr;
    logic do_rd;
    @(negedge clk);
    bus.write_en = we;
    bus.read_en  = re;
    bus.data_i   = din;
    @(posedge clk);
    occ   = exp_q.size();
    do_rd = re && (occ > 0);
    do_wr = we && ((occ < D) || re);
    if (we && (occ == D) && !re) exp_ovf = 1'b1;
    if (re && (occ == 0))        exp_unf = 1'b1;
    if (do_rd) exp_data = exp_q.pop_front();
    if (do_wr) exp_q.push_back(din);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < D; i++) step(tag, 1'b0, 1'b1, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_reset();
    reset_i      = 1'b1;
    bus.write_en = 1'b1;
    bus.read_en  = 1'b0;
    bus.data_i   = 8'hAA;

    // Reset with write_en high: nothing may be stored.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset_i      = 1'b0;
    bus.write_en = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("post_reset");

    // Fill 0..7 then drain.
    for (int i = 0; i < D; i++) step("fill", 1'b1, 1'b0, W'(i));
    drain("drain");

    // Read while empty: data_o stays 7.
    step("underflow", 1'b0, 1'b1, '0);
    check("underflow.hold7", 32'(bus.data_o), 32'd7);

    // Write 0..9 from empty: 8 and 9 dropped.
    for (int i = 0; i < 10; i++) step("overflow", 1'b1, 1'b0, W'(i));
    drain("overflow_drain");

    // Full FIFO with simultaneous read/write.
    for (int i = 0; i < D; i++) step("refill", 1'b1, 1'b0, W'(i));
    for (int i = 0; i < D; i++) step("simul", 1'b1, 1'b1, W'(16 + i));
    drain("simul_drain");
    check("simul_drain.last", 32'(bus.data_o), 32'd23);

    // Write + read when empty: write only.
    step("empty_wr_rd", 1'b1, 1'b1, 8'h5C);
    step("empty_wr_rd_pop", 1'b0, 1'b1, '0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom_range(0, 255)));
    end

    // Fill partially, then reset asynchronously between edges.
    for (int i = 0; i < 5; i++) step("pre_reset", 1'b1, 1'b0, W'($urandom_range(0, 255)));
    step("pre_reset_rd", 1'b0, 1'b1, '0);
    @(negedge clk);
    bus.write_en = 1'b1;
    #2;
    reset_i = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    reset_i      = 1'b0;
    bus.write_en = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("async_reset_release");

    // More random traffic, biased toward the full boundary.
    for (int i = 0; i < 400; i++) begin
      step("rand2", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), W'($urandom_range(0, 255)));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock synchronous FIFO buffering byte-wide data between a producer and a consumer in the same clock domain.
- Circular memory with separate read/write pointers and an occupancy counter.
- Drives full/empty status flags.
- Read data is registered, one cycle of latency.

Parameters:
- WIDTH, 8, data bit width of data_i/data_o.
- DEPTH, 8, number of entries; power of two, >= 2.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- write_en  input  1  write request; data_i captured on the same rising edge.
- read_en  input  1  read request; oldest entry moved to data_o.
- data_i  input  WIDTH  write data.
- data_o  output  WIDTH  registered read data.
- full_o  output  1  high when count == DEPTH.
- empty_o  output  1  high when count == 0.

Behaviour:
- Reset (reset_i high, asynchronous assert, release sampled on clk_i):
  - write_ptr = 0, read_ptr = 0, count = 0.
  - data_o = 0, empty_o = 1, full_o = 0.
  - Memory contents not reset.
- Pointer and count widths:
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is $clog2(DEPTH)+1 bits and ranges 0..DEPTH.
- Flags:
  - full_o and empty_o decode combinationally from the count register.
  - They therefore update in the cycle after the edge that changed count.
- Write accepted (wr_ok) = write_en && (!full_o || read_en).
  - On wr_ok: mem[write_ptr] <= data_i; write_ptr increments.
- Read accepted (rd_ok) = read_en && !empty_o.
  - On rd_ok: data_o <= mem[read_ptr]; read_ptr increments.
- Read latency:
  - data_o is valid the cycle after the accepting edge.
  - data_o holds its last value when no read is accepted.
- Count update:
  - wr_ok only: +1.
  - rd_ok only: -1.
  - Both, or neither: unchanged.
- Boundary conditions:
  - Write when full without read: dropped; no state change.
  - Write + read when full: both accepted; full_o stays 1.
  - Read when empty: ignored; data_o unchanged, empty_o stays 1.
  - Write + read when empty: write only; count becomes 1.
  - Reset mid-operation: immediately returns to the reset state; all stored data is discarded.
- No X-propagation: outputs are defined from the first reset onward.

Optional Feature:
- Macro SYNC_FIFO_ERR_FLAGS_EN.
- When defined, adds two ports:
  - overflow_o (1 bit): sticky, set on a dropped write (write_en && full_o && !read_en).
  - underflow_o (1 bit): sticky, set on read_en && empty_o.
  - Both clear only on reset_i.
- When not defined, these ports and their logic do not exist.
- Core behaviour is identical with or without the macro.

Decomposition:
- Package sync_fifo_pkg:
  - Constants DEFAULT_WIDTH = 8 and DEFAULT_DEPTH = 8.
  - Function for pointer width ($clog2 wrapper).
- Sub-module sync_fifo_mem:
  - DEPTH x WIDTH register array, one write port, registered read port.
  - Instantiated by sync_fifo.
  - Pointer, count and flag logic stay in the top.

Test Plan:
- Reset:
  - Assert reset_i with write_en = 1.
  - Expect empty_o = 1, full_o = 0, data_o = 0, and no write taken.
- Fill:
  - Write data 0..7 on 8 consecutive edges.
  - Expect empty_o = 0 after the first edge and full_o = 1 after the 8th.
- Drain:
  - Assert read_en for 8 edges.
  - Expect data_o = 0,1,..,7, each one cycle after its read edge.
  - Expect empty_o = 1 after the 8th, full_o = 0 after the first.
- Underflow:
  - One read while empty.
  - Expect data_o to remain 7, empty_o = 1, pointers unchanged.
  - Expect underflow_o = 1 if SYNC_FIFO_ERR_FLAGS_EN is defined.
- Overflow:
  - Write 0..9 from empty.
  - Expect full_o = 1 after the 8th edge and values 8, 9 dropped.
  - A following drain returns 0..7.
  - Expect overflow_o = 1 if the macro is defined.
- Simultaneous:
  - From full (0..7 stored), assert write_en and read_en for 8 edges with data_i = 16..23.
  - Expect data_o = 0..7, full_o to stay 1, and count = 8 throughout.
  - A following drain returns 16..23.
